// File: rtl/sensor_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module   : sensor_conditioner_if
// Brief    : Rising-edge event handshake between sensor_conditioner and its
//            consumer (pending set, lowest index, valid/ack).
// Revision : 1.0  initial release
// ============================================================================
interface sensor_conditioner_if #(
    parameter int WIDTH = 24
);
    logic             event_valid;
    logic [4:0]       event_index;
    logic             event_ack;
    logic [WIDTH-1:0] pending_mask;

    modport master (
        output event_valid,
        output event_index,
        output pending_mask,
        input  event_ack
    );

    modport slave (
        input  event_valid,
        input  event_index,
        input  pending_mask,
        output event_ack
    );
endinterface
`default_nettype wire

// File: rtl/sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : sensor_conditioner
// Brief    : Synchronises and debounces the raw sensor pins into a clean word
//            and reports each clean rising edge as a pending event.
// Revision : 1.0  initial release
// ============================================================================
module sensor_conditioner #(
    parameter int WIDTH        = 24,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 8
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic [WIDTH-1:0] sensor_raw,
    output logic      [31:0]      sensor_clean,
    output logic                  overrun,
    sensor_conditioner_if.master  ev
);

    localparam int c_PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int c_CW = $clog2(STABLE_TICKS);

    localparam logic [c_PW-1:0] c_PRE_MAX = c_PW'(TICK_DIV - 1);
    localparam logic [c_PW-1:0] c_PRE_ONE = c_PW'(1);
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(STABLE_TICKS - 1);
    localparam logic [c_CW-1:0] c_CNT_ONE = c_CW'(1);
    localparam logic [WIDTH-1:0] c_BIT0   = WIDTH'(1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [c_PW-1:0]  r_prescaler;
    logic [c_CW-1:0]  r_cnt [WIDTH];
    logic [WIDTH-1:0] r_clean;
    logic [WIDTH-1:0] r_pending;
    logic             r_overrun;

    logic             w_tick;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_ack_mask;
    logic             w_valid;
    logic [4:0]       w_index;

    // Two-flop synchroniser; nothing downstream looks at sensor_raw.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= sensor_raw;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_prescaler <= '0;
        end else if (r_prescaler == c_PRE_MAX) begin
            r_prescaler <= '0;
        end else begin
            r_prescaler <= r_prescaler + c_PRE_ONE;
        end
    end

    assign w_tick = (r_prescaler == c_PRE_MAX);

    // A clean bit flips on the STABLE_TICKS-th consecutive disagreeing tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_clean <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else if (w_tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sync2[i] == r_clean[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == c_CNT_MAX) begin
                    r_clean[i] <= ~r_clean[i];
                    r_cnt[i]   <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + c_CNT_ONE;
                end
            end
        end
    end

    always_comb begin
        w_rise = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_rise[i] = w_tick && (r_sync2[i] != r_clean[i]) &&
                        (r_cnt[i] == c_CNT_MAX) && !r_clean[i];
        end
    end

    // Lowest set pending bit wins; scanning downward leaves the lowest.
    always_comb begin
        w_index = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_index = 5'(i);
            end
        end
    end

    assign w_valid    = |r_pending;
    assign w_ack_mask = (ev.event_ack && w_valid) ? (c_BIT0 << w_index) : '0;

    // A new rise beats an ack on the same bit, so the set term is OR-ed last.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pending <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~w_ack_mask) | w_rise;
            if (|(w_rise & r_pending & ~w_ack_mask)) begin
                r_overrun <= 1'b1;
            end
        end
    end

    always_comb begin
        sensor_clean              = '0;
        sensor_clean[WIDTH-1:0]   = r_clean;
    end

    assign overrun         = r_overrun;
    assign ev.event_valid  = w_valid;
    assign ev.event_index  = w_index;
    assign ev.pending_mask = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_sensor_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_sensor_conditioner
// Brief    : Directed self-checking bench for sensor_conditioner
//            (TICK_DIV=4, STABLE_TICKS=3, WIDTH=24).
// Revision : 1.0  initial release
// ============================================================================
module tb_sensor_conditioner;

    localparam int W  = 24;
    localparam int TD = 4;
    localparam int ST = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  sensor_raw = '0;
    logic [31:0]   sensor_clean;
    logic          overrun;

    int n_cmp = 0;
    int n_err = 0;

    sensor_conditioner_if #(.WIDTH(W)) ev ();

    sensor_conditioner #(
        .WIDTH        (W),
        .TICK_DIV     (TD),
        .STABLE_TICKS (ST)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .sensor_raw   (sensor_raw),
        .sensor_clean (sensor_clean),
        .overrun      (overrun),
        .ev           (ev)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    // Steps until sensor_clean[b]==v or maxc cycles pass; n returns cycles taken.
    task automatic wait_bit(input string tag, input int b, input logic v,
                            input int maxc, output int n);
        n = 0;
        while (n < maxc && sensor_clean[b] !== v) begin
            step();
            n++;
        end
        check(tag, 32'(sensor_clean[b]), 32'(v));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        ev.event_ack = 1'b0;

        // Reset with all pins high
        sensor_raw = '1;
        do_reset();
        check("rst_clean",   sensor_clean,    32'h0);
        check("rst_valid",   32'(ev.event_valid), 32'h0);
        check("rst_overrun", 32'(overrun),    32'h0);
        check("rst_pending", 32'(ev.pending_mask), 32'h0);
        n = 0;
        while (n < 20 && sensor_clean !== 32'h00FFFFFF) begin
            step();
            n++;
        end
        check("rst_settle_cycles", 32'(n), 32'd12);
        check("rst_clean_full",  sensor_clean, 32'h00FFFFFF);
        check("rst_pend_full",   32'(ev.pending_mask), 32'h00FFFFFF);
        check("rst_index0",      32'(ev.event_index), 32'h0);
        check("rst_valid1",      32'(ev.event_valid), 32'h1);
        ev.event_ack = 1'b1;
        for (int i = 0; i < W; i++) begin
            check("drain_index", 32'(ev.event_index), 32'(i));
            step();
        end
        ev.event_ack = 1'b0;
        check("drain_valid0",  32'(ev.event_valid), 32'h0);
        check("drain_overrun", 32'(overrun), 32'h0);

        // Single rise on bit 5
        sensor_raw = '0;
        do_reset();
        sensor_raw[5] = 1'b1;
        wait_bit("s2_rise", 5, 1'b1, 20, n);
        check("s2_latency_window", 32'(n >= 11 && n <= 14), 32'h1);
        check("s2_valid",   32'(ev.event_valid), 32'h1);
        check("s2_index",   32'(ev.event_index), 32'd5);
        check("s2_pending", 32'(ev.pending_mask), 32'h20);
        ev.event_ack = 1'b1;
        step();
        ev.event_ack = 1'b0;
        check("s2_valid_after_ack", 32'(ev.event_valid), 32'h0);
        check("s2_clean_hold", sensor_clean, 32'h20);

        // Glitch on bit 9 lasting 6 cycles
        sensor_raw[9] = 1'b1;
        repeat (6) step();
        sensor_raw[9] = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            check("s3_clean", sensor_clean, 32'h20);
            check("s3_pend",  32'(ev.pending_mask), 32'h0);
        end

        // Bits 3 and 17 together
        sensor_raw[3]  = 1'b1;
        sensor_raw[17] = 1'b1;
        wait_bit("s4_rise3", 3, 1'b1, 20, n);
        check("s4_clean",   sensor_clean, 32'h00020028);
        check("s4_pending", 32'(ev.pending_mask), 32'h020008);
        check("s4_index3",  32'(ev.event_index), 32'd3);
        ev.event_ack = 1'b1;
        step();
        check("s4_index17", 32'(ev.event_index), 32'd17);
        check("s4_valid_mid", 32'(ev.event_valid), 32'h1);
        step();
        ev.event_ack = 1'b0;
        check("s4_valid0", 32'(ev.event_valid), 32'h0);

        // Bit 2 rise, fall, rise without ack -> overrun
        sensor_raw[2] = 1'b1;
        wait_bit("s5_rise1", 2, 1'b1, 20, n);
        check("s5_pend1", 32'(ev.pending_mask), 32'h4);
        sensor_raw[2] = 1'b0;
        wait_bit("s5_fall", 2, 1'b0, 20, n);
        check("s5_ovr_before", 32'(overrun), 32'h0);
        check("s5_pend_fall",  32'(ev.pending_mask), 32'h4);
        check("s5_valid_fall", 32'(ev.event_valid), 32'h1);
        sensor_raw[2] = 1'b1;
        wait_bit("s5_rise2", 2, 1'b1, 20, n);
        check("s5_overrun", 32'(overrun), 32'h1);
        check("s5_pend2",   32'(ev.pending_mask), 32'h4);
        ev.event_ack = 1'b1;
        step();
        ev.event_ack = 1'b0;
        check("s5_valid_ack", 32'(ev.event_valid), 32'h0);
        check("s5_ovr_ack",   32'(overrun), 32'h1);
        repeat (5) step();
        check("s5_ovr_sticky", 32'(overrun), 32'h1);
        sensor_raw = '0;
        do_reset();
        check("s5_ovr_reset",   32'(overrun), 32'h0);
        check("s5_clean_reset", sensor_clean, 32'h0);

        // Ack on the same edge bit 7 rises again
        sensor_raw[7] = 1'b1;
        wait_bit("s6_rise1", 7, 1'b1, 20, n);
        check("s6_pend1", 32'(ev.pending_mask), 32'h80);
        sensor_raw[7] = 1'b0;
        wait_bit("s6_fall", 7, 1'b0, 20, n);
        sensor_raw[7] = 1'b1;
        repeat (11) step();
        check("s6_pre_clean", sensor_clean, 32'h0);
        check("s6_pre_pend",  32'(ev.pending_mask), 32'h80);
        ev.event_ack = 1'b1;
        step();
        ev.event_ack = 1'b0;
        check("s6_rose",    sensor_clean, 32'h80);
        check("s6_pend",    32'(ev.pending_mask), 32'h80);
        check("s6_overrun", 32'(overrun), 32'h0);
        ev.event_ack = 1'b1;
        step();
        ev.event_ack = 1'b0;
        check("s6_valid0", 32'(ev.event_valid), 32'h0);
        ev.event_ack = 1'b1;
        step();
        step();
        ev.event_ack = 1'b0;
        check("s6_idle_pend",  32'(ev.pending_mask), 32'h0);
        check("s6_idle_ovr",   32'(overrun), 32'h0);
        check("s6_idle_clean", sensor_clean, 32'h80);
        check("s6_idle_index", 32'(ev.event_index), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sensor_conditioner.md
Name: sensor_conditioner

Overview:
Front-end stage for the 24 sensor lines. It turns raw, asynchronous, bouncy sensor pins into the clean 32-bit sensor_input word. That word is consumed by the VGA controller and by the processor at address 0.
It also reports each newly-asserted sensor through a valid/ack event interface, so the processor does not have to poll for edges.

Parameters:
WIDTH, 24, number of sensor lines (maximum 32)
TICK_DIV, 50000, clock cycles per debounce sample tick (1 ms at 50 MHz)
STABLE_TICKS, 8, consecutive disagreeing ticks required before a clean bit changes (minimum 2)

Ports:
clock  in  1  system clock; all logic is on its rising edge
reset  in  1  synchronous, active-high reset
sensor_raw  in  WIDTH  raw asynchronous sensor pins
sensor_clean  out  32  debounced sensor word; bits [WIDTH-1:0] carry sensor state, upper bits are always 0
event_valid  out  1  at least one rising event is pending
event_index  out  5  index of the lowest-numbered pending event
event_ack  in  1  consumer accepts the event currently on event_index
pending_mask  out  WIDTH  all pending rising events
overrun  out  1  sticky flag: a rising event was lost

Behaviour:
- Reset (synchronous, highest priority): clears the synchronizers, prescaler, per-bit counters, sensor_clean, pending_mask and overrun. All outputs read 0 on the cycle after reset is sampled. Reset asserted mid-debounce discards the partial count.
- Synchronizer: two flip-flops per bit, giving sync[i]. No other logic uses sensor_raw directly.
- Prescaler: counts 0..TICK_DIV-1 and wraps to 0.
  - tick = (prescaler == TICK_DIV-1); tick is combinational and lasts one cycle.
  - The first tick after reset occurs on cycle TICK_DIV-1.
- Per-bit debounce counter cnt[i], width clog2(STABLE_TICKS). Action on each tick:
  - sync[i] == clean[i]: cnt[i] <= 0.
  - sync[i] != clean[i] and cnt[i] < STABLE_TICKS-1: cnt[i] increments.
  - sync[i] != clean[i] and cnt[i] == STABLE_TICKS-1: clean[i] toggles and cnt[i] <= 0.
  - Net effect: clean[i] changes on the STABLE_TICKS-th consecutive disagreeing tick.
  - Between ticks, cnt and clean hold.
- Latency: once a raw change is stable, the clean bit follows after
  - minimum 2 + (STABLE_TICKS-1)*TICK_DIV + 1 cycles,
  - maximum 2 + STABLE_TICKS*TICK_DIV cycles.
- Glitch rejection: any sync pulse seen on at most STABLE_TICKS-1 ticks causes no change on sensor_clean.
- Rising event: pending[i] is set on the same edge that clean[i] goes 0->1. A falling clean edge generates no event.
- Event outputs are combinational from the pending register only:
  - event_valid = |pending.
  - event_index = lowest set bit of pending; it is 0 when nothing is pending.
- Handshake:
  - event_ack with event_valid=1 clears pending[event_index] at the next edge.
  - event_ack with event_valid=0 is ignored.
  - The consumer may hold ack high; one event is then consumed per cycle, in ascending index order.
- Simultaneous events on one bit: if a new rise and an ack of that same bit occur in one cycle, the set wins, so pending stays 1 and no overrun is flagged.
- Overrun: a rise on a bit that is already pending and not being acked that cycle sets overrun. Overrun stays 1 until reset. pending stays 1 (the events merge).
- Multiple bits may toggle on the same tick; all of their pending bits set together.

Test Plan:
All scenarios use TICK_DIV=4, STABLE_TICKS=3, WIDTH=24.
- Reset with sensor_raw=24'hFFFFFF held -> sensor_clean=0, event_valid=0 and overrun=0 on the first cycle after reset. sensor_clean reaches 32'h00FFFFFF within 2+12 cycles of reset release. pending_mask=24'hFFFFFF and event_index=0.
- sensor_raw[5] driven 0->1 and held -> sensor_clean[5] rises between 11 and 14 cycles later. event_valid=1 and event_index=5 appear on the same cycle. One event_ack pulse -> event_valid=0 next cycle.
- 6-cycle high glitch on sensor_raw[9] (at most 2 ticks observed) -> sensor_clean and pending_mask unchanged for 30 cycles.
- Bits 3 and 17 become stable-high together -> pending_mask=24'h020008 and event_index=3. First ack -> event_index=17. Second ack -> event_valid=0.
- Bit 2 rises, then falls, then rises again with no ack in between -> overrun=1 after the second clean rise; pending_mask[2]=1. overrun stays 1 through a subsequent ack, and only reset clears it.
- Ack asserted for bit 7 on the same edge that bit 7 rises again -> pending[7] stays 1 and overrun stays 0. event_ack with event_valid=0 -> no state change.
